// File: rtl/key_debounce_pulse_pkg.sv
// Shared constants for the pushbutton conditioning stage: FSM encodings,
// 50 MHz timing defaults and the counter-width helper.
package key_debounce_pulse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RELEASED     = 2'd0;
  localparam state_t ST_PRESS_WAIT   = 2'd1;
  localparam state_t ST_PRESSED      = 2'd2;
  localparam state_t ST_RELEASE_WAIT = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 0.1 s

  // Width that holds (largest cycle count - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if ($clog2(m) < 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_pulse_sync2.sv
// Two-flop synchroniser for an asynchronous level input; both stages reset
// to RESET_VAL so a released active-low key reads as idle out of reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= {2{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces a raw active-low pushbutton and produces one registered strobe per
// confirmed press, plus optional auto-repeat strobes while the key is held.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse,
  output logic key_down
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  logic s_n;

  state_t          state_reg, state_next;
  logic [CW-1:0]   deb_cnt_reg, deb_cnt_next;
  logic [CW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic            rpt_phase_reg, rpt_phase_next;
  logic            pulse_reg, pulse_next;
  logic            down_reg, down_next;
  logic            rpt_hit;

  sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(CLOCK_50),
    .rst(reset),
    .d  (key_n),
    .q  (s_n)
  );

  // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_PERIOD.
  always_comb begin
    rpt_hit = 1'b0;
    if (REPEAT_EN != 0) begin
      rpt_hit = rpt_phase_reg ? (hold_cnt_reg == PERIOD_LAST)
                              : (hold_cnt_reg == DELAY_LAST);
    end
  end

  always_comb begin
    state_next     = state_reg;
    deb_cnt_next   = deb_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    rpt_phase_next = rpt_phase_reg;
    pulse_next     = 1'b0;
    down_next      = down_reg;

    case (state_reg)
      ST_RELEASED: begin
        down_next = 1'b0;
        if (!s_n) begin
          state_next   = ST_PRESS_WAIT;
          deb_cnt_next = '0;
        end
      end

      ST_PRESS_WAIT: begin
        down_next = 1'b0;
        if (s_n) begin
          state_next = ST_RELEASED;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next     = ST_PRESSED;
          pulse_next     = 1'b1;
          down_next      = 1'b1;
          hold_cnt_next  = '0;
          rpt_phase_next = 1'b0;
        end else begin
          deb_cnt_next = sat_inc(deb_cnt_reg);
        end
      end

      // A release seen on the cycle a repeat would fire takes priority.
      ST_PRESSED: begin
        down_next = 1'b1;
        if (s_n) begin
          state_next   = ST_RELEASE_WAIT;
          deb_cnt_next = '0;
        end else if (rpt_hit) begin
          pulse_next     = 1'b1;
          hold_cnt_next  = '0;
          rpt_phase_next = 1'b1;
        end else if (REPEAT_EN != 0) begin
          hold_cnt_next = sat_inc(hold_cnt_reg);
        end
      end

      ST_RELEASE_WAIT: begin
        down_next = 1'b1;
        if (!s_n) begin
          state_next = ST_PRESSED;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next = ST_RELEASED;
          down_next  = 1'b0;
        end else begin
          deb_cnt_next = sat_inc(deb_cnt_reg);
        end
      end

      default: begin
        state_next = ST_RELEASED;
        down_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RELEASED;
      deb_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      rpt_phase_reg <= 1'b0;
      pulse_reg     <= 1'b0;
      down_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      deb_cnt_reg   <= deb_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      rpt_phase_reg <= rpt_phase_next;
      pulse_reg     <= pulse_next;
      down_reg      <= down_next;
    end
  end

  assign press_pulse = pulse_reg;
  assign key_down    = down_reg;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: run-length behavioural model checked every
// cycle, plus directed scenarios with hand-computed edge numbers.
module tb_key_debounce_pulse;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic pp_a, kd_a, pp_b, kd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut_a (
    .CLOCK_50(clk), .reset(rst), .key_n(key_n), .press_pulse(pp_a), .key_down(kd_a)
  );

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut_b (
    .CLOCK_50(clk), .reset(rst), .key_n(key_n), .press_pulse(pp_b), .key_down(kd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once DEB+1 consecutive synchronised
  // samples disagree with it; repeats fire on held-cycle counts
  // DLY, DLY+PER, DLY+2*PER, ... where a held cycle is one whose sample and
  // previous sample are both "pressed" while already debounced down.
  bit m_sh0 = 1'b1, m_sh1 = 1'b1, m_prev = 1'b1, m_d = 1'b0, m_s, m_dbefore;
  int m_run = 0, m_ticks = 0;
  bit exp_pp_a = 1'b0, exp_pp_b = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_sh0 = 1'b1; m_sh1 = 1'b1; m_prev = 1'b1; m_d = 1'b0;
        m_run = 0; m_ticks = 0; exp_pp_a = 1'b0; exp_pp_b = 1'b0;
      end else begin
        m_s = m_sh1;
        m_sh1 = m_sh0;
        m_sh0 = key_n;
        exp_pp_a = 1'b0;
        exp_pp_b = 1'b0;
        m_dbefore = m_d;
        if (m_s == m_d) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
          m_d = !m_d;
          m_run = 0;
          if (m_d) begin
            exp_pp_a = 1'b1;
            exp_pp_b = 1'b1;
            m_ticks = 0;
          end
        end else if (m_dbefore && !m_s && !m_prev) begin
          m_ticks++;
          if (m_ticks == DLY || (m_ticks > DLY && (m_ticks - DLY) % PER == 0))
            exp_pp_a = 1'b1;
        end
        m_prev = m_s;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("pulse_rep", pp_a, exp_pp_a);
        check("pulse_norep", pp_b, exp_pp_b);
        check("key_down_rep", kd_a, m_d);
        check("key_down_norep", kd_b, m_d);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_n = 1'b1;
    end
  endtask

  int pe_a[$];
  int cnt_b, fall_k, kd6, first_rep, kd_low_seen, cnt_any;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Clean press held through repeats, then released.
    pe_a.delete(); cnt_b = 0; fall_k = 0; kd6 = -1;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      key_n = (k <= 37) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (pp_a) pe_a.push_back(k);
      if (pp_b) cnt_b++;
      if (k == 6) kd6 = kd_a;
      if (k > 7 && !kd_a && fall_k == 0) fall_k = k;
    end
    $display("press/repeat/release: %0d rep pulses, %0d norep pulses, key_down fell at edge %0d",
             pe_a.size(), cnt_b, fall_k);
    check("rep_count", pe_a.size(), 9);
    check("first_pulse_edge", pe_a[0], 7);
    check("repeat1_edge", pe_a[1], 17);
    check("repeat2_edge", pe_a[2], 20);
    check("last_repeat_edge", pe_a[8], 38);
    check("norep_count", cnt_b, 1);
    check("key_down_before_confirm", kd6, 0);
    check("release_fall_edge", fall_k, 44);
    idle(4);

    // Bounce: 2 low, 1 high, 2 low, then high.
    cnt_any = 0; kd_low_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      key_n = (k <= 2 || k == 4 || k == 5) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (pp_a || pp_b) cnt_any++;
      if (kd_a || kd_b) kd_low_seen++;
    end
    $display("bounce: %0d pulses, %0d key_down cycles", cnt_any, kd_low_seen);
    check("bounce_pulses", cnt_any, 0);
    check("bounce_key_down", kd_low_seen, 0);

    // Release bounce: high for edges 10-11, hold timer freezes 3 cycles.
    first_rep = 0; kd_low_seen = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      key_n = (k == 10 || k == 11) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      if (pp_a && k > 7 && first_rep == 0) first_rep = k;
      if (k >= 7 && !kd_a) kd_low_seen++;
    end
    $display("release bounce: first repeat at edge %0d, key_down drops %0d", first_rep, kd_low_seen);
    check("rb_first_repeat", first_rep, 20);
    check("rb_key_down_held", kd_low_seen, 0);
    idle(10);

    // Reset mid-hold, landing in the cycle the press pulse is high.
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      key_n = 1'b0;
      if (k < 7) @(posedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-hold: press_pulse=%0d key_down=%0d", pp_a, kd_a);
    check("rst_pulse_clear", pp_a, 0);
    check("rst_key_down_clear", kd_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_rep = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (pp_a && first_rep == 0) first_rep = k;
    end
    $display("after reset with key held: pulse at edge %0d", first_rep);
    check("rst_repress_edge", first_rep, 7);
    idle(12);

    // Randomised segments with occasional asynchronous resets.
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      logic v;
      v = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 45) : $urandom_range(1, 6);
      if ($urandom_range(0, 39) == 0) begin
        $display("random seg %0d: async reset", seg);
        do_reset();
      end
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        key_n = v;
      end
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
